// File: rtl/cpu_pkg.sv
// Shared pipeline encodings: fetch mux selects and the interrupt-entry state set.
package cpu_pkg;

    localparam logic [1:0] PC_SRC_DMEM  = 2'd0;
    localparam logic [1:0] PC_SRC_RB_D  = 2'd1;
    localparam logic [1:0] PC_SRC_IMEM  = 2'd2;
    localparam logic [1:0] PC_SRC_RB_EX = 2'd3;

    localparam logic [1:0] ADDR_SRC_PC  = 2'd0;
    localparam logic [1:0] ADDR_SRC_VEC = 2'd1;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH,
        VEC_RD,
        VEC_LD,
        CLR
    } intr_state_t;

endpackage

// File: rtl/intr_entry_sequencer.sv
// Interrupt entry: freeze fetch, drain the pipe, push the return PC, load the ISR
// vector from instruction memory, then clear the request and interrupt enable.
module intr_entry_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0]  VEC_ADDR     = 8'h01,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MEM_LAT      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       intr_flag,
    input  logic       ie,
    input  logic       hlt,
    input  logic       stall,
    input  logic       branch_tkn,
    input  logic [7:0] pc,
    input  logic       push_ready,
    input  logic       cu_pc_en,
    input  logic       cu_pc_load,
    input  logic [1:0] cu_pc_src,
    input  logic [1:0] cu_addr_src,
    output logic       pc_en,
    output logic       pc_load,
    output logic [1:0] pc_src,
    output logic [1:0] addr_src,
    output logic       flush_ir,
    output logic       push_valid,
    output logic [7:0] push_data,
    output logic       int_clr,
    output logic       ie_clr,
    output logic       busy
);

    // VEC_ADDR is applied by the mem_addr_mux when addr_src selects ADDR_SRC_VEC.
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);

    intr_state_t state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            push_data <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) push_data <= pc;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        pc_en      = cu_pc_en;
        pc_load    = cu_pc_load;
        pc_src     = cu_pc_src;
        addr_src   = cu_addr_src;
        flush_ir   = 1'b0;
        push_valid = 1'b0;
        int_clr    = 1'b0;
        ie_clr     = 1'b0;

        case (state)
            IDLE: begin
                // A taken branch wins; the request stays latched for the next clean cycle.
                if (intr_flag && ie && !hlt && !stall && !branch_tkn) begin
                    accept    = 1'b1;
                    cnt_nxt   = DRAIN_INIT;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                pc_en    = 1'b0;
                pc_load  = 1'b0;
                flush_ir = 1'b1;
                if (cnt == 3'd0) state_nxt = PUSH;
                else             cnt_nxt   = cnt - 3'd1;
            end
            PUSH: begin
                pc_en      = 1'b0;
                pc_load    = 1'b0;
                flush_ir   = 1'b1;
                push_valid = 1'b1;
                if (push_ready) begin
                    cnt_nxt   = LAT_INIT;
                    state_nxt = VEC_RD;
                end
            end
            VEC_RD: begin
                pc_en    = 1'b0;
                pc_load  = 1'b0;
                addr_src = ADDR_SRC_VEC;
                flush_ir = 1'b1;
                if (cnt == 3'd0) state_nxt = VEC_LD;
                else             cnt_nxt   = cnt - 3'd1;
            end
            VEC_LD: begin
                // I_data now holds M[VEC_ADDR]; steer it into PC.
                pc_en     = 1'b0;
                pc_load   = 1'b1;
                pc_src    = PC_SRC_IMEM;
                addr_src  = ADDR_SRC_VEC;
                flush_ir  = 1'b1;
                state_nxt = CLR;
            end
            CLR: begin
                int_clr   = 1'b1;
                ie_clr    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_intr_entry_sequencer.sv
// Directed and random stimulus against a timeline model of interrupt entry.
module tb_intr_entry_sequencer;

    localparam int D = 3;
    localparam int L = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       intr_flag, ie, hlt, stall, branch_tkn, push_ready;
    logic [7:0] pc;
    logic       cu_pc_en, cu_pc_load;
    logic [1:0] cu_pc_src, cu_addr_src;
    logic       pc_en, pc_load, flush_ir, push_valid, int_clr, ie_clr, busy;
    logic [1:0] pc_src, addr_src;
    logic [7:0] push_data;

    intr_entry_sequencer #(.VEC_ADDR(8'h01), .DRAIN_CYCLES(D), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst), .intr_flag(intr_flag), .ie(ie), .hlt(hlt),
        .stall(stall), .branch_tkn(branch_tkn), .pc(pc), .push_ready(push_ready),
        .cu_pc_en(cu_pc_en), .cu_pc_load(cu_pc_load), .cu_pc_src(cu_pc_src),
        .cu_addr_src(cu_addr_src), .pc_en(pc_en), .pc_load(pc_load), .pc_src(pc_src),
        .addr_src(addr_src), .flush_ir(flush_ir), .push_valid(push_valid),
        .push_data(push_data), .int_clr(int_clr), .ie_clr(ie_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Timeline model: an entry is the accept cycle plus the push handshake cycle.
    int         cyc = 0;
    bit         active = 1'b0;
    int         acc = 0;
    int         hs = -1;
    logic [7:0] pd = 8'h00;

    // Observations gathered per directed test.
    int clr_seen, pv_cnt, busy_cnt, load_cyc, clr_cyc, hs_obs;

    // 0 idle, 1 drain, 2 push, 3 vector read, 4 vector load, 5 clear
    function automatic int phase_now();
        int k, m;
        if (!active) return 0;
        k = cyc - acc;
        if (k >= 1 && k <= D) return 1;
        if (hs < 0) return 2;
        m = cyc - hs;
        if (m >= 1 && m <= L) return 3;
        if (m == L + 1) return 4;
        return 5;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        clr_seen = 0; pv_cnt = 0; busy_cnt = 0;
        load_cyc = -1; clr_cyc = -1; hs_obs = -1;
    endtask

    // Called just after a falling edge with the inputs for this cycle already set.
    task automatic tick();
        int  ph;
        bit  pass;
        cu_pc_en    = 1'($urandom);
        cu_pc_load  = 1'($urandom);
        cu_pc_src   = 2'($urandom);
        cu_addr_src = 2'($urandom);
        if (rst) begin active = 1'b0; pd = 8'h00; end
        #1;
        ph   = phase_now();
        pass = (ph == 0 || ph == 5);
        chk("busy",       busy,       ph != 0);
        chk("pc_en",      pc_en,      pass ? cu_pc_en : 1'b0);
        chk("pc_load",    pc_load,    ph == 4 ? 1'b1 : (pass ? cu_pc_load : 1'b0));
        chk("pc_src",     pc_src,     ph == 4 ? 2'd2 : cu_pc_src);
        chk("addr_src",   addr_src,   (ph == 3 || ph == 4) ? 2'd1 : cu_addr_src);
        chk("flush_ir",   flush_ir,   ph >= 1 && ph <= 4);
        chk("push_valid", push_valid, ph == 2);
        chk("push_data",  push_data,  pd);
        chk("int_clr",    int_clr,    ph == 5);
        chk("ie_clr",     ie_clr,     ph == 5);

        if (int_clr) begin clr_seen++; if (clr_cyc < 0) clr_cyc = cyc; end
        if (push_valid) pv_cnt++;
        if (busy) busy_cnt++;
        if (busy && pc_load && load_cyc < 0) load_cyc = cyc;
        if (push_valid && push_ready && hs_obs < 0) hs_obs = cyc;

        if (!rst) begin
            if (ph == 0) begin
                if (intr_flag && ie && !hlt && !stall && !branch_tkn) begin
                    active = 1'b1; acc = cyc; hs = -1; pd = pc;
                end
            end else if (ph == 2) begin
                if (push_ready) hs = cyc;
            end else if (ph == 5) begin
                active = 1'b0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic quiet();
        intr_flag = 0; ie = 1; hlt = 0; stall = 0; branch_tkn = 0; push_ready = 1;
    endtask

    initial begin
        int t0;
        rst = 1; quiet(); pc = 8'h00;
        cu_pc_en = 0; cu_pc_load = 0; cu_pc_src = 0; cu_addr_src = 0;
        @(negedge clk);

        // reset state
        clear_obs();
        tick(); tick();
        chk("reset_pd", push_data, 8'h00);
        rst = 0;
        tick();

        // basic entry, pc=2A
        clear_obs();
        pc = 8'h2A; intr_flag = 1; t0 = cyc;
        tick();
        intr_flag = 0; pc = 8'h2B;
        repeat (10) tick();
        chk("basic_push_data", push_data, 8'h2A);
        chk("basic_pv_cnt", 8'(pv_cnt), 8'd1);
        chk("basic_load_ofs", 8'(load_cyc - t0), 8'(D + 1 + L + 1));
        chk("basic_clr_ofs", 8'(clr_cyc - t0), 8'(D + 1 + L + 2));
        chk("basic_clr_cnt", 8'(clr_seen), 8'd1);

        // masked by ie, then by hlt
        clear_obs();
        intr_flag = 1; ie = 0;
        repeat (20) tick();
        ie = 1; hlt = 1;
        repeat (20) tick();
        chk("mask_busy_cnt", 8'(busy_cnt), 8'd0);
        chk("mask_clr_cnt", 8'(clr_seen), 8'd0);
        quiet();
        tick();

        // branch in the same cycle as the request
        clear_obs();
        intr_flag = 1; branch_tkn = 1; pc = 8'h3C;
        tick();
        branch_tkn = 0; pc = 8'h40; t0 = cyc;
        tick();
        intr_flag = 0; pc = 8'h41;
        chk("br_busy", busy, 1'b1);
        chk("br_push_data", push_data, 8'h40);
        repeat (10) tick();
        chk("br_load_ofs", 8'(load_cyc - t0), 8'(D + 1 + L + 1));

        // push_ready held low for 4 PUSH cycles
        clear_obs();
        intr_flag = 1; push_ready = 0; pc = 8'h77;
        tick();
        intr_flag = 0; pc = 8'h00;
        repeat (D + 4) tick();
        push_ready = 1;
        repeat (8) tick();
        chk("bp_pv_cnt", 8'(pv_cnt), 8'd5);
        chk("bp_load_after_hs", 8'(load_cyc - hs_obs), 8'(L + 1));
        chk("bp_push_data", push_data, 8'h77);

        // one-cycle request pulse
        clear_obs();
        intr_flag = 1; pc = 8'h90;
        tick();
        intr_flag = 0;
        repeat (10) tick();
        chk("pulse_clr_cnt", 8'(clr_seen), 8'd1);

        // reset asserted in the middle of DRAIN
        clear_obs();
        intr_flag = 1; pc = 8'h55;
        tick();
        intr_flag = 0;
        tick();
        rst = 1;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_flush", flush_ir, 1'b0);
        chk("rst_pv", push_valid, 1'b0);
        rst = 0;
        repeat (3) tick();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            intr_flag  = ($urandom_range(99) < 70);
            ie         = ($urandom_range(99) < 80);
            hlt        = ($urandom_range(99) < 10);
            stall      = ($urandom_range(99) < 20);
            branch_tkn = ($urandom_range(99) < 20);
            push_ready = ($urandom_range(99) < 60);
            pc         = 8'($urandom);
            rst        = ($urandom_range(199) == 0);
            tick();
        end
        rst = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
